// File: rtl/bu_result_collector.sv
// bu_result_collector
//   Collects FP32 results from bu_ndiag into a small FIFO. It writes them to
//   the result matrix memory in row-major order from BASE_ADDR, keeps sticky
//   exception status, and pulses done once the N_ROWS x N_COLS matrix has
//   been captured and fully written.
//
//   Optional build macro: BU_COLLECT_FLUSH_ZERO_EN
//     When defined, entries flagged zero or underflow are written as a signed
//     zero {sign, 31'b0}. When undefined, the data is written unmodified.
//
// Ports
//   clock, aclr_n            : rising-edge clock, async active-low reset
//   start                    : one-cycle pulse; arms a capture (ignored while busy)
//   bu_result/bu_*           : result word, its valid and its flags from bu_ndiag
//   mem_wr_en/ready/addr/data: write port to the result matrix memory
//   busy, done               : capture in progress / end-of-matrix pulse
//   fifo_full                : FIFO holds DEPTH entries
//   drop_err, sticky_ovf/unf : sticky status, cleared by start
module bu_result_collector #(
    parameter int DEPTH     = 8,
    parameter int N_ROWS    = 4,
    parameter int N_COLS    = 4,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              start,
    input  logic [31:0]       bu_result,
    input  logic              bu_data_available,
    input  logic              bu_zero,
    input  logic              bu_overflow,
    input  logic              bu_underflow,
    output logic              mem_wr_en,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic              fifo_full,
    output logic              drop_err,
    output logic              sticky_ovf,
    output logic              sticky_unf
);

    localparam int TOTAL = N_ROWS * N_COLS;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int KW    = $clog2(TOTAL + 1);
    localparam int RW    = $clog2(N_ROWS + 1);
    localparam int LW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;

    typedef struct packed {
        logic        ovf;
        logic        unf;
        logic        zero;
        logic [31:0] res;
    } entry_t;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t        state, state_nxt;
    entry_t        fifo_mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [KW-1:0] cap_cnt;
    logic [RW-1:0] row;
    logic [LW-1:0] col;
    logic [31:0]   wr_word;
    logic          avail_col, push, pop, last_cap, last_wr, arm;
    logic          unused_head;

    assign busy      = (state != IDLE);
    assign fifo_full = (count == CW'(DEPTH));
    assign mem_wr_en = busy && (count != '0);
    assign pop       = mem_wr_en && mem_wr_ready;
    assign avail_col = (state == COLLECT) && bu_data_available;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign push      = avail_col && (!fifo_full || pop);
    assign last_cap  = avail_col && (cap_cnt == KW'(TOTAL - 1));
    // Count==0 in DRAIN cannot normally happen (the final capture lands in
    // the FIFO), but it must not leave the FSM stuck.
    assign last_wr   = (state == DRAIN) && (((count == CW'(1)) && pop) || (count == '0));
    assign arm       = (state == IDLE) && start;

    assign head = fifo_mem[rptr];

`ifdef BU_COLLECT_FLUSH_ZERO_EN
    assign wr_word = (head.unf || head.zero) ? {head.res[31], 31'b0} : head.res;
`else
    assign wr_word = head.res;
`endif
    // Overflow (and, without flushing, zero/underflow) is kept per entry for
    // status only; it never shapes the written word.
    assign unused_head = &{1'b0, head.ovf, head.unf, head.zero};

    // Gated so the port reads 0 whenever no write is requested.
    assign mem_wr_data = mem_wr_en ? wr_word : 32'h0;
    assign mem_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(row) * ADDR_W'(N_COLS) + ADDR_W'(col);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = COLLECT;
            COLLECT: if (last_cap) state_nxt = DRAIN;
            DRAIN:   if (last_wr)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Storage needs no reset: contents are only read when count != 0.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wptr] <= entry_t'{bu_overflow, bu_underflow, bu_zero, bu_result};
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            cap_cnt    <= '0;
            row        <= '0;
            col        <= '0;
            done       <= 1'b0;
            drop_err   <= 1'b0;
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= last_wr;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (arm) begin
                cap_cnt    <= '0;
                row        <= '0;
                col        <= '0;
                drop_err   <= 1'b0;
                sticky_ovf <= 1'b0;
                sticky_unf <= 1'b0;
            end else begin
                // A dropped result still consumes its matrix position.
                if (avail_col) cap_cnt <= cap_cnt + KW'(1);
                if ((avail_col && !push) || ((state == DRAIN) && bu_data_available))
                    drop_err <= 1'b1;
                if (push) begin
                    sticky_ovf <= sticky_ovf | bu_overflow;
                    sticky_unf <= sticky_unf | bu_underflow;
                end
                // Address counters advance on accepted writes only.
                if (pop) begin
                    if (col == LW'(N_COLS - 1)) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + LW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bu_result_collector.sv
// Scoreboard bench for bu_result_collector: stimulus pushes expected
// {addr, data} writes into a queue; a negedge monitor pops and compares each
// accepted write and checks done timing.
module tb_bu_result_collector;

    localparam int DEPTH = 8, N_ROWS = 4, N_COLS = 4, ADDR_W = 6, BASE = 0;

`ifdef BU_COLLECT_FLUSH_ZERO_EN
    localparam logic [31:0] UNF_EXP = 32'h80000000;
`else
    localparam logic [31:0] UNF_EXP = 32'h80000001;
`endif

    logic              clock = 1'b0;
    logic              aclr_n, start;
    logic [31:0]       bu_result;
    logic              bu_data_available, bu_zero, bu_overflow, bu_underflow;
    logic              mem_wr_en, mem_wr_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic              busy, done, fifo_full, drop_err, sticky_ovf, sticky_unf;

    bu_result_collector #(.DEPTH(DEPTH), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
                          .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clock(clock), .aclr_n(aclr_n), .start(start), .bu_result(bu_result),
        .bu_data_available(bu_data_available), .bu_zero(bu_zero),
        .bu_overflow(bu_overflow), .bu_underflow(bu_underflow),
        .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .busy(busy), .done(done), .fifo_full(fifo_full),
        .drop_err(drop_err), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf));

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0, n_pass = 0;
    int   cyc = 0, last_wr_cyc = -10, wr_cnt = 0, done_cnt = 0;
    logic rdy_next = 1'b0;

    // 2.0 .. 17.0
    logic [31:0] mat_tab [16] = '{
        32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
        32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000,
        32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000,
        32'h41600000, 32'h41700000, 32'h41800000, 32'h41880000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (mem_wr_en && mem_wr_ready) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), e.addr);
                chk("wr_data", mem_wr_data, e.data);
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_after_last_write", cyc, last_wr_cyc + 1);
            chk("done_queue_empty", exp_q.size(), 0);
        end
    end

    task automatic drive(input logic av, input logic [31:0] d,
                         input logic o, input logic u, input logic z);
        @(posedge clock); #1;
        bu_data_available = av; bu_result = d;
        bu_overflow = o; bu_underflow = u; bu_zero = z;
        mem_wr_ready = rdy_next;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        @(posedge clock); #1;
        start = 1'b1; bu_data_available = 1'b0; mem_wr_ready = rdy_next;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic push_exp(input int a, input logic [31:0] d);
        exp_t e;
        e.addr = 32'(BASE + a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic run_matrix(input int gap);
        for (int i = 0; i < 16; i++) begin
            push_exp(i, mat_tab[i]);
            drive(1'b1, mat_tab[i], 1'b0, 1'b0, 1'b0);
            if (i < 15) repeat (gap) idle();
        end
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("done_seen", done_cnt, target);
    endtask

    initial begin
        int base;
        aclr_n = 1'b0; start = 1'b0; bu_result = '0; bu_data_available = 1'b0;
        bu_zero = 1'b0; bu_overflow = 1'b0; bu_underflow = 1'b0; mem_wr_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_outputs", {26'b0, mem_wr_en, busy, done, fifo_full, drop_err, sticky_ovf}, 32'h0);
        chk("rst_unf", 32'(sticky_unf), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_data", mem_wr_data, 32'h0);
        @(posedge clock); #1 aclr_n = 1'b1;

        // Results in IDLE are ignored
        rdy_next = 1'b1;
        drive(1'b1, 32'h3F800000, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h3F800000, 1'b1, 1'b1, 1'b0);
        idle();
        @(negedge clock);
        chk("idle_quiet", {28'b0, busy, drop_err, sticky_ovf, sticky_unf}, 32'h0);
        chk("idle_no_write", wr_cnt, 0);

        // Basic matrix plus a 17th result while draining
        do_start();
        run_matrix(1);
        drive(1'b1, 32'h42000000, 1'b0, 1'b0, 1'b0);
        idle();
        wait_done(1);
        @(negedge clock);
        chk("basic_writes", wr_cnt, 16);
        chk("basic_busy_after", 32'(busy), 32'h0);
        chk("extra_drop_err", 32'(drop_err), 32'h1);
        chk("basic_no_flags", {sticky_ovf, sticky_unf}, 32'h0);

        // Backpressure, flags, full push+pop, drop
        base = wr_cnt;
        rdy_next = 1'b0;
        do_start();
        chk("start_clears_drop", 32'(drop_err), 32'h0);
        for (int i = 0; i < 8; i++) begin
            push_exp(i, (i == 1) ? UNF_EXP : mat_tab[i]);
            drive(1'b1, (i == 1) ? 32'h80000001 : mat_tab[i], i == 0, i == 1, 1'b0);
        end
        idle();
        @(negedge clock);
        chk("bp_full", 32'(fifo_full), 32'h1);
        chk("bp_wr_en", 32'(mem_wr_en), 32'h1);
        chk("bp_addr", 32'(mem_addr), 32'h0);
        chk("bp_data", mem_wr_data, mat_tab[0]);
        chk("sticky_ovf", 32'(sticky_ovf), 32'h1);
        chk("sticky_unf", 32'(sticky_unf), 32'h1);
        @(negedge clock);
        chk("bp_addr_stable", 32'(mem_addr), 32'h0);
        chk("bp_data_stable", mem_wr_data, mat_tab[0]);
        rdy_next = 1'b1;
        push_exp(8, 32'h41A00000);
        drive(1'b1, 32'h41A00000, 1'b0, 1'b0, 1'b0);
        rdy_next = 1'b0;
        idle();
        @(negedge clock);
        chk("pp_still_full", 32'(fifo_full), 32'h1);
        chk("pp_no_drop", 32'(drop_err), 32'h0);
        chk("pp_head_addr", 32'(mem_addr), 32'h1);
        chk("pp_head_data", mem_wr_data, UNF_EXP);
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clock);
        chk("full_drop_err", 32'(drop_err), 32'h1);
        rdy_next = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_exp(9 + i, mat_tab[10 + i]);
            drive(1'b1, mat_tab[10 + i], 1'b0, 1'b0, 1'b0);
            idle();
        end
        wait_done(2);
        chk("bp_writes", wr_cnt - base, 15);
        chk("flags_hold", {drop_err, sticky_ovf, sticky_unf}, 32'h7);

        // Reset mid-operation
        rdy_next = 1'b0;
        do_start();
        @(negedge clock);
        chk("start_clears_flags", {busy, drop_err, sticky_ovf, sticky_unf}, 32'h8);
        base = wr_cnt;
        for (int i = 0; i < 7; i++) begin
            push_exp(i, mat_tab[i]);
            drive(1'b1, mat_tab[i], 1'b0, 1'b0, 1'b0);
        end
        rdy_next = 1'b1;
        idle();
        for (int n = 0; n < 50 && (wr_cnt - base) < 5; n++) @(negedge clock);
        chk("pre_reset_writes", wr_cnt - base, 5);
        @(posedge clock); #1;
        aclr_n = 1'b0; mem_wr_ready = 1'b0; rdy_next = 1'b0;
        #1;
        chk("async_rst_outputs", {25'b0, mem_wr_en, busy, done, fifo_full, drop_err, sticky_ovf, sticky_unf}, 32'h0);
        chk("async_rst_addr_data", 32'(mem_addr) | mem_wr_data, 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        chk("no_done_on_reset", done_cnt, 2);
        @(posedge clock); #1 aclr_n = 1'b1;
        base = wr_cnt;
        rdy_next = 1'b1;
        do_start();
        run_matrix(0);
        idle();
        wait_done(3);
        chk("restart_writes", wr_cnt - base, 16);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
